// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// One add-3/shift step per clock; result and done pulse appear together,
// WIDTH+1 cycles after an accepted start.
module bin_to_bcd_seq #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [BW-1:0]     scratch_q, scratch_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;

    logic [BW-1:0]     adj;
    logic [BW-1:0]     scratch_step;
    logic [WIDTH-1:0]  shift_step;

    // One double-dabble step: add 3 to every digit >= 5 (all from pre-step values), then shift.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        {scratch_step, shift_step} = {adj[BW-2:0], shift_q, 1'b0};
    end

    // Next-state and datapath update; result is published on the edge entering StDone
    // so done and the new bcd_out are visible in the same cycle.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shift_d   = bin_in;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                shift_d   = shift_step;
                scratch_d = scratch_step;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    bcd_d   = scratch_step;
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset wins over everything, including mid-conversion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign valid   = valid_q;
    assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq with a decimal reference model for the sweep.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] bin_in;
    logic        busy;
    logic        done;
    logic        valid;
    logic [31:0] bcd_out;

    int n_tests = 0;
    int n_fail  = 0;

    bin_to_bcd_seq #(
        .WIDTH (16),
        .DIGITS(8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bin_in (bin_in),
        .busy   (busy),
        .done   (done),
        .valid  (valid),
        .bcd_out(bcd_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Wait for idle, start a conversion, and return cycles from the accept edge to done.
    task automatic convert(input logic [15:0] v, output int lat);
        for (int i = 0; i < 4 && busy === 1'b1; i++) step();
        bin_in = v;
        start  = 1'b1;
        step();
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
    endtask

    function automatic logic [15:0] sweep_val(input int j, input int n);
        int unsigned t;
        t = (j == n - 1) ? 65535 : j * 43;
        return t[15:0];
    endfunction

    int          lat;
    int          dones;
    int          done_at;
    int          j;
    int          since;
    int          guard;
    localparam int NVec = 1500;

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        step();
        step();
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_bcd",   bcd_out,        32'd0);
        reset = 1'b0;
        step();
        check("idle_busy", {31'd0, busy},  32'd0);

        // Max value, latency and handshake
        convert(16'hFFFF, lat);
        check("t1_lat",   lat,             32'd17);
        check("t1_bcd",   bcd_out,         32'h0006_5535);
        check("t1_valid", {31'd0, valid},  32'd1);
        check("t1_busy",  {31'd0, busy},   32'd1);
        step();
        check("t1_done_pulse", {31'd0, done}, 32'd0);
        check("t1_idle",  {31'd0, busy},   32'd0);
        check("t1_hold",  bcd_out,         32'h0006_5535);

        // RPN-style operands
        convert(16'h005A, lat);
        check("t2_bcd_a", bcd_out, 32'h0000_0090);
        convert(16'hFFA5, lat);
        check("t2_bcd_b", bcd_out, 32'h0006_5445);

        // Zero operand; old result held until done
        for (int i = 0; i < 4 && busy === 1'b1; i++) step();
        bin_in = 16'h0000;
        start  = 1'b1;
        step();
        start = 1'b0;
        lat   = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            lat++;
        end
        check("t3_hold",      bcd_out,        32'h0006_5445);
        check("t3_no_done",   {31'd0, done},  32'd0);
        check("t3_busy",      {31'd0, busy},  32'd1);
        while (done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        check("t3_lat", lat,     32'd17);
        check("t3_bcd", bcd_out, 32'h0000_0000);

        // Starts during a conversion are ignored, bin_in changes have no effect
        for (int i = 0; i < 4 && busy === 1'b1; i++) step();
        bin_in  = 16'h0001;
        start   = 1'b1;
        step();
        dones   = 0;
        done_at = 0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 3 || c == 10) begin
                start  = 1'b1;
                bin_in = 16'h1234;
            end else begin
                start = 1'b0;
            end
            step();
            if (done === 1'b1) begin
                dones++;
                done_at = c;
            end
        end
        start = 1'b0;
        check("t4_dones",   dones,   32'd1);
        check("t4_done_at", done_at, 32'd16);
        check("t4_bcd",     bcd_out, 32'h0000_0001);

        // Reset mid-conversion discards everything
        bin_in = 16'h270F;
        start  = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_busy",  {31'd0, busy},  32'd0);
        check("t5_bcd",   bcd_out,        32'd0);
        check("t5_valid", {31'd0, valid}, 32'd0);
        check("t5_done",  {31'd0, done},  32'd0);
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (done === 1'b1) dones++;
        end
        check("t5_no_done", dones, 32'd0);
        convert(16'h270F, lat);
        check("t5_lat",    lat,            32'd17);
        check("t5_bcd",    bcd_out,        32'h0000_9999);
        check("t5_valid2", {31'd0, valid}, 32'd1);

        // Back-to-back sweep with start held high
        for (int i = 0; i < 4 && busy === 1'b1; i++) step();
        j      = 0;
        since  = 0;
        guard  = 0;
        bin_in = sweep_val(0, NVec);
        start  = 1'b1;
        while (j < NVec && guard < NVec * 18 + 100) begin
            step();
            since++;
            guard++;
            if (done === 1'b1) begin
                check("t6_bcd", bcd_out, to_bcd(int'(sweep_val(j, NVec))));
                check("t6_spacing", since, (j == 0) ? 32'd17 : 32'd18);
                since = 0;
                j++;
                if (j < NVec) bin_in = sweep_val(j, NVec);
            end
        end
        start = 1'b0;
        check("t6_count", j, NVec);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
